// File: rtl/conv_frame_writer.sv
// Frame writer: tracks the raster position of convolution samples, zeroes the
// border, converts to saturated magnitude and buffers {addr, value} in a small
// first-word fall-through FIFO that drives a ready/valid frame-memory write port.
module conv_frame_writer #(
  parameter int unsigned WIDTH      = 1280,
  parameter int unsigned HEIGHT     = 960,
  parameter int unsigned ADDR_W     = 21,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned BORDER     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [11:0]       conv_data,
  input  logic              conv_valid,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [11:0]       wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow
);

  localparam int unsigned DATA_W = 12;
  localparam int unsigned XW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned YW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned CW     = $clog2(FIFO_DEPTH + 1);
  localparam logic [DATA_W-1:0] MAG_MAX = 12'h7FF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_t            state_q, state_d;
  logic              done_d;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic [ADDR_W-1:0] addr_q;
  entry_t            fifo_q [FIFO_DEPTH];
  entry_t            fifo_d [FIFO_DEPTH];
  entry_t            new_entry;
  logic [CW-1:0]     cnt_q, cnt_d, wr_idx;
  logic              valid_q;
  logic              sample, last_px, full, pop, push, drop, border;
  logic [DATA_W-1:0] neg, mag, pix;

  assign sample  = (state_q == RUN) && conv_valid;
  assign last_px = (x_q == XW'(WIDTH - 1)) && (y_q == YW'(HEIGHT - 1));
  assign full    = (cnt_q == CW'(FIFO_DEPTH));
  assign pop     = valid_q && wr_ready;
  // A full FIFO still takes a sample when the head leaves in the same cycle.
  assign push    = sample && (!full || pop);
  assign drop    = sample && full && !pop;

  assign wr_valid = valid_q;
  assign wr_addr  = fifo_q[0].addr;
  assign wr_data  = fifo_q[0].data;
  assign busy     = (state_q != IDLE);

  // Border zeroing and saturated magnitude; -2048 clamps to 2047.
  always_comb begin
    neg    = DATA_W'(~conv_data + 12'd1);
    mag    = conv_data;
    if (conv_data[DATA_W-1]) begin
      mag = neg[DATA_W-1] ? MAG_MAX : neg;
    end
    border = (32'(x_q) < BORDER) || (32'(y_q) < BORDER);
    pix    = border ? '0 : mag;
  end

  // Shift-style FIFO: slot 0 is the head, so it holds its value once emptied.
  always_comb begin
    fifo_d         = fifo_q;
    new_entry.addr = addr_q;
    new_entry.data = pix;
    wr_idx         = pop ? (cnt_q - CW'(1)) : cnt_q;
    if (pop) begin
      for (int i = 0; i < int'(FIFO_DEPTH) - 1; i++) begin
        if (CW'(i + 1) < cnt_q) fifo_d[i] = fifo_q[i + 1];
      end
    end
    if (push) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        if (wr_idx == CW'(i)) fifo_d[i] = new_entry;
      end
    end
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  // Next-state logic for the frame capture sequence.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = RUN;
      RUN:   if (sample && last_px) state_d = DRAIN;
      DRAIN: begin
        if ((cnt_q == '0) && !valid_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Raster position and address; dropped samples still advance the address.
  always_ff @(posedge clk) begin
    if (rst || ((state_q == IDLE) && start)) begin
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
    end else if (sample) begin
      addr_q <= addr_q + ADDR_W'(1);
      if (x_q == XW'(WIDTH - 1)) begin
        x_q <= '0;
        y_q <= (y_q == YW'(HEIGHT - 1)) ? '0 : (y_q + YW'(1));
      end else begin
        x_q <= x_q + XW'(1);
      end
    end
  end

  // FIFO storage, occupancy and write-valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_q[i] <= '0;
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= (cnt_d != '0);
      fifo_q  <= fifo_d;
    end
  end

  // Sticky overflow and the end-of-frame pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= done_d;
      if ((state_q == IDLE) && start) overflow <= 1'b0;
      else if (drop)                  overflow <= 1'b1;
    end
  end

endmodule
